// File: rtl/udma_tx_ch_ctrl.sv
// uDMA TX channel controller: fetches elements from L2 through a single-outstanding
// read port and hands them to the UART peripheral, with a depth-1 queued config.
module udma_tx_ch_ctrl #(
  parameter int L2_WIDTH_NOAL = 19,
  parameter int TRANS_SIZE    = 20,
  parameter int DATA_SIZE     = 32
) (
  input  logic                     sys_clk_i,
  input  logic                     rst_i,
  input  logic [L2_WIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]    cfg_size_i,
  input  logic [1:0]               cfg_datasize_i,
  input  logic                     cfg_continuous_i,
  input  logic                     cfg_en_i,
  input  logic                     cfg_clr_i,
  output logic                     cfg_en_o,
  output logic                     cfg_pending_o,
  output logic [L2_WIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]    cfg_bytes_left_o,
  input  logic                     data_req_i,
  output logic                     data_gnt_o,
  output logic [DATA_SIZE-1:0]     data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     l2_req_o,
  output logic [L2_WIDTH_NOAL-1:0] l2_addr_o,
  input  logic                     l2_gnt_i,
  input  logic [DATA_SIZE-1:0]     l2_rdata_i,
  input  logic                     l2_rvalid_i
);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, L2_REQ, L2_WAIT, DATA_OUT, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     en_q, en_d, pend_q, pend_d;
  logic                     cont_q, cont_d, sh_cont_q, sh_cont_d;
  logic [1:0]               ds_q, ds_d, sh_ds_q, sh_ds_d;
  logic [L2_WIDTH_NOAL-1:0] addr_q, addr_d, start_q, start_d, sh_addr_q, sh_addr_d;
  logic [TRANS_SIZE-1:0]    left_q, left_d, size_q, size_d, sh_size_q, sh_size_d;
  logic [DATA_SIZE-1:0]     data_q, data_d, shifted, mask;
  logic [2:0]               step;
  logic [L2_WIDTH_NOAL-1:0] addr_inc;
  logic [TRANS_SIZE-1:0]    left_dec;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      pend_q    <= 1'b0;
      cont_q    <= 1'b0;
      sh_cont_q <= 1'b0;
      ds_q      <= '0;
      sh_ds_q   <= '0;
      addr_q    <= '0;
      start_q   <= '0;
      sh_addr_q <= '0;
      left_q    <= '0;
      size_q    <= '0;
      sh_size_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      pend_q    <= pend_d;
      cont_q    <= cont_d;
      sh_cont_q <= sh_cont_d;
      ds_q      <= ds_d;
      sh_ds_q   <= sh_ds_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      sh_addr_q <= sh_addr_d;
      left_q    <= left_d;
      size_q    <= size_d;
      sh_size_q <= sh_size_d;
      data_q    <= data_d;
    end
  end

  assign cfg_en_o         = en_q;
  assign cfg_pending_o    = pend_q;
  assign cfg_curr_addr_o  = addr_q;
  assign cfg_bytes_left_o = left_q;
  assign data_o           = data_q;
  assign data_valid_o     = (state_q == DATA_OUT);
  assign l2_req_o         = (state_q == L2_REQ);
  assign l2_addr_o        = {addr_q[L2_WIDTH_NOAL-1:2], 2'b00};
  assign data_gnt_o       = l2_req_o & l2_gnt_i;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    pend_d    = pend_q;
    cont_d    = cont_q;
    sh_cont_d = sh_cont_q;
    ds_d      = ds_q;
    sh_ds_d   = sh_ds_q;
    addr_d    = addr_q;
    start_d   = start_q;
    sh_addr_d = sh_addr_q;
    left_d    = left_q;
    size_d    = size_q;
    sh_size_d = sh_size_q;
    data_d    = data_q;

    case (ds_q)
      2'd0:    begin step = 3'd1; mask = DATA_SIZE'(8'hFF);   end
      2'd1:    begin step = 3'd2; mask = DATA_SIZE'(16'hFFFF); end
      default: begin step = 3'd4; mask = '1;                  end
    endcase
    shifted  = l2_rdata_i >> {addr_q[1:0], 3'b000};
    addr_inc = addr_q + L2_WIDTH_NOAL'(step);
    left_dec = (left_q > TRANS_SIZE'(step)) ? left_q - TRANS_SIZE'(step) : '0;

    if (cfg_clr_i) begin
      en_d      = 1'b0;
      pend_d    = 1'b0;
      sh_cont_d = 1'b0;
      sh_ds_d   = '0;
      sh_addr_d = '0;
      sh_size_d = '0;
      left_d    = '0;
      // An already granted read must still be swallowed before going idle
      case (state_q)
        L2_REQ:         state_d = l2_gnt_i ? DRAIN : IDLE;
        L2_WAIT, DRAIN: state_d = l2_rvalid_i ? IDLE : DRAIN;
        default:        state_d = IDLE;
      endcase
    end else begin
      if (cfg_en_i && en_q) begin
        sh_addr_d = cfg_startaddr_i;
        sh_size_d = cfg_size_i;
        sh_ds_d   = cfg_datasize_i;
        sh_cont_d = cfg_continuous_i;
        pend_d    = 1'b1;
      end
      case (state_q)
        IDLE: if (cfg_en_i && cfg_size_i != '0) begin
          addr_d  = cfg_startaddr_i;
          start_d = cfg_startaddr_i;
          left_d  = cfg_size_i;
          size_d  = cfg_size_i;
          ds_d    = cfg_datasize_i;
          cont_d  = cfg_continuous_i;
          en_d    = 1'b1;
          state_d = WAIT_REQ;
        end
        WAIT_REQ: if (data_req_i) state_d = L2_REQ;
        L2_REQ:   if (l2_gnt_i) state_d = L2_WAIT;
        L2_WAIT: if (l2_rvalid_i) begin
          data_d  = shifted & mask;
          state_d = DATA_OUT;
        end
        DATA_OUT: if (data_ready_i) begin
          addr_d = addr_inc;
          left_d = left_dec;
          if (left_dec != '0) begin
            state_d = WAIT_REQ;
          end else if (pend_q || cfg_en_i) begin
            // A config arriving on the very last handshake is taken directly
            addr_d  = cfg_en_i ? cfg_startaddr_i  : sh_addr_q;
            start_d = cfg_en_i ? cfg_startaddr_i  : sh_addr_q;
            left_d  = cfg_en_i ? cfg_size_i       : sh_size_q;
            size_d  = cfg_en_i ? cfg_size_i       : sh_size_q;
            ds_d    = cfg_en_i ? cfg_datasize_i   : sh_ds_q;
            cont_d  = cfg_en_i ? cfg_continuous_i : sh_cont_q;
            pend_d  = 1'b0;
            state_d = WAIT_REQ;
          end else if (cont_q) begin
            addr_d  = start_q;
            left_d  = size_q;
            state_d = WAIT_REQ;
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
        DRAIN:   if (l2_rvalid_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_tx_ch_ctrl.sv
// Directed bench for udma_tx_ch_ctrl with a small L2 memory model of configurable latency.
module tb_udma_tx_ch_ctrl;
  localparam int AW = 19;
  localparam int TW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_startaddr;
  logic [TW-1:0] cfg_size;
  logic [1:0]    cfg_datasize;
  logic          cfg_continuous, cfg_en, cfg_clr;
  logic          cfg_en_o, cfg_pending_o;
  logic [AW-1:0] cfg_curr_addr_o;
  logic [TW-1:0] cfg_bytes_left_o;
  logic          data_req, data_gnt_o, data_valid_o, data_ready;
  logic [DW-1:0] data_o;
  logic          l2_req_o, l2_gnt, l2_rvalid;
  logic [AW-1:0] l2_addr_o;
  logic [DW-1:0] l2_rdata;

  int checks = 0;
  int errors = 0;
  int rv_lat = 1;
  int rv_cnt = 0;
  logic [DW-1:0] rv_data;
  logic [31:0] mem [int unsigned];

  always #5 clk = ~clk;

  udma_tx_ch_ctrl #(.L2_WIDTH_NOAL(AW), .TRANS_SIZE(TW), .DATA_SIZE(DW)) dut (
    .sys_clk_i(clk), .rst_i(rst),
    .cfg_startaddr_i(cfg_startaddr), .cfg_size_i(cfg_size), .cfg_datasize_i(cfg_datasize),
    .cfg_continuous_i(cfg_continuous), .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
    .cfg_en_o(cfg_en_o), .cfg_pending_o(cfg_pending_o),
    .cfg_curr_addr_o(cfg_curr_addr_o), .cfg_bytes_left_o(cfg_bytes_left_o),
    .data_req_i(data_req), .data_gnt_o(data_gnt_o), .data_o(data_o),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready),
    .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_gnt_i(l2_gnt),
    .l2_rdata_i(l2_rdata), .l2_rvalid_i(l2_rvalid)
  );

  // L2 model: always grants, returns the word rv_lat cycles after the grant
  always @(posedge clk) begin
    l2_rvalid <= 1'b0;
    if (rst) begin
      rv_cnt <= 0;
    end else if (l2_req_o && l2_gnt) begin
      if (rv_lat <= 1) begin
        l2_rvalid <= 1'b1;
        l2_rdata  <= mem.exists(int'(l2_addr_o)) ? mem[int'(l2_addr_o)] : 32'h0;
      end else begin
        rv_cnt  <= rv_lat - 1;
        rv_data <= mem.exists(int'(l2_addr_o)) ? mem[int'(l2_addr_o)] : 32'h0;
      end
    end else if (rv_cnt != 0) begin
      rv_cnt <= rv_cnt - 1;
      if (rv_cnt == 1) begin
        l2_rvalid <= 1'b1;
        l2_rdata  <= rv_data;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_start(input logic [AW-1:0] a, input logic [TW-1:0] sz,
                           input logic [1:0] ds, input logic c);
    @(negedge clk);
    cfg_startaddr = a; cfg_size = sz; cfg_datasize = ds; cfg_continuous = c; cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
  endtask

  // One element: request pulse, wait for valid, check data, handshake. Returns latency.
  task automatic elem(input string tag, input logic [DW-1:0] exp, output int lat);
    int n;
    @(negedge clk); data_req = 1'b1;
    @(negedge clk); data_req = 1'b0;
    n = 0;
    while (!data_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    lat = n + 1;
    chk({tag, "_valid"}, 64'(data_valid_o), 64'd1);
    chk({tag, "_data"}, 64'(data_o), 64'(exp));
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    64'(cfg_en_o), 64'd0);
    chk({tag, "_pend"},  64'(cfg_pending_o), 64'd0);
    chk({tag, "_addr"},  64'(cfg_curr_addr_o), 64'd0);
    chk({tag, "_left"},  64'(cfg_bytes_left_o), 64'd0);
    chk({tag, "_dval"},  64'(data_valid_o), 64'd0);
    chk({tag, "_data"},  64'(data_o), 64'd0);
    chk({tag, "_l2req"}, 64'(l2_req_o), 64'd0);
    chk({tag, "_l2adr"}, 64'(l2_addr_o), 64'd0);
    chk({tag, "_gnt"},   64'(data_gnt_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic saw_v, saw_g, held_ok;
    logic [DW-1:0] held;
    rst = 1'b1; cfg_startaddr = '0; cfg_size = '0; cfg_datasize = '0;
    cfg_continuous = 1'b0; cfg_en = 1'b0; cfg_clr = 1'b0;
    data_req = 1'b0; data_ready = 1'b0; l2_gnt = 1'b1;
    mem[32'h100] = 32'h44332211;
    mem[32'h200] = 32'hAABBCCDD;
    mem[32'h204] = 32'h00001234;
    mem[32'h040] = 32'h0000BBAA;
    mem[32'h080] = 32'h00006655;
    mem[32'h010] = 32'h000000EE;
    mem[32'h300] = 32'hDEADBEEF;
    mem[32'h400] = 32'h12345678;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // size 0 start is ignored
    cfg_start(19'h100, 20'd0, 2'd0, 1'b0);
    chk("size0_en", 64'(cfg_en_o), 64'd0);

    // byte transfer
    cfg_start(19'h100, 20'd4, 2'd0, 1'b0);
    chk("byte_en", 64'(cfg_en_o), 64'd1);
    chk("byte_left0", 64'(cfg_bytes_left_o), 64'd4);
    chk("byte_addr0", 64'(cfg_curr_addr_o), 64'h100);
    elem("byte0", 32'h11, lat);
    chk("byte_latency", 64'(lat), 64'd3);
    chk("byte_left1", 64'(cfg_bytes_left_o), 64'd3);
    elem("byte1", 32'h22, lat);
    elem("byte2", 32'h33, lat);
    elem("byte3", 32'h44, lat);
    chk("byte_end_en", 64'(cfg_en_o), 64'd0);
    chk("byte_end_left", 64'(cfg_bytes_left_o), 64'd0);

    // halfword transfer, unaligned start
    cfg_start(19'h202, 20'd3, 2'd1, 1'b0);
    elem("half0", 32'hAABB, lat);
    chk("half_left1", 64'(cfg_bytes_left_o), 64'd1);
    elem("half1", 32'h1234, lat);
    chk("half_left0", 64'(cfg_bytes_left_o), 64'd0);
    chk("half_addr", 64'(cfg_curr_addr_o), 64'h206);
    chk("half_en", 64'(cfg_en_o), 64'd0);

    // continuous
    cfg_start(19'h40, 20'd2, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("cont_addr", 64'(cfg_curr_addr_o), 64'h40 + 64'(i % 2));
      elem("cont", (i % 2 == 0) ? 32'hAA : 32'hBB, lat);
      chk("cont_en", 64'(cfg_en_o), 64'd1);
    end
    chk("cont_addr_end", 64'(cfg_curr_addr_o), 64'h41);
    @(negedge clk); cfg_clr = 1'b1;
    @(negedge clk); cfg_clr = 1'b0;
    chk("cont_clr_en", 64'(cfg_en_o), 64'd0);
    chk("cont_clr_left", 64'(cfg_bytes_left_o), 64'd0);

    // pending
    cfg_start(19'h80, 20'd2, 2'd0, 1'b0);
    cfg_start(19'h10, 20'd1, 2'd0, 1'b0);
    chk("pend_set", 64'(cfg_pending_o), 64'd1);
    chk("pend_addr_keep", 64'(cfg_curr_addr_o), 64'h80);
    elem("pend0", 32'h55, lat);
    chk("pend_still", 64'(cfg_pending_o), 64'd1);
    elem("pend1", 32'h66, lat);
    chk("pend_clr", 64'(cfg_pending_o), 64'd0);
    chk("pend_addr", 64'(cfg_curr_addr_o), 64'h10);
    chk("pend_left", 64'(cfg_bytes_left_o), 64'd1);
    chk("pend_en", 64'(cfg_en_o), 64'd1);
    elem("pend2", 32'hEE, lat);
    chk("pend_end_en", 64'(cfg_en_o), 64'd0);

    // clear in flight: clr while in L2_WAIT, rvalid 4 cycles after grant
    rv_lat = 4;
    cfg_start(19'h300, 20'd4, 2'd2, 1'b0);
    @(negedge clk); data_req = 1'b1;
    @(negedge clk); data_req = 1'b0;
    @(negedge clk);
    cfg_clr = 1'b1; data_req = 1'b1;
    @(negedge clk); cfg_clr = 1'b0;
    chk("clr_en", 64'(cfg_en_o), 64'd0);
    chk("clr_pend", 64'(cfg_pending_o), 64'd0);
    chk("clr_left", 64'(cfg_bytes_left_o), 64'd0);
    saw_v = 1'b0; saw_g = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw_v |= data_valid_o;
      saw_g |= data_gnt_o | l2_req_o;
    end
    data_req = 1'b0;
    chk("clr_no_valid", 64'(saw_v), 64'd0);
    chk("clr_no_fetch", 64'(saw_g), 64'd0);
    rv_lat = 1;
    cfg_start(19'h300, 20'd4, 2'd2, 1'b0);
    elem("after_clr", 32'hDEADBEEF, lat);
    chk("after_clr_en", 64'(cfg_en_o), 64'd0);

    // backpressure then reset mid DATA_OUT
    cfg_start(19'h400, 20'd4, 2'd2, 1'b0);
    @(negedge clk); data_req = 1'b1;
    @(negedge clk); data_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_valid", 64'(data_valid_o), 64'd1);
    chk("bp_data", 64'(data_o), 64'h12345678);
    held = data_o;
    held_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(data_valid_o === 1'b1 && data_o === held)) held_ok = 1'b0;
    end
    chk("bp_held", 64'(held_ok), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
